// File: rtl/ram_if.sv
// Bus bundle for the single-port data memory: shared address, write data/enable and
// registered read data.
interface ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wren;
  logic [DATA_WIDTH-1:0] salida;

  modport master (
    output data,
    output address,
    output wren,
    input  salida
  );

  modport slave (
    input  data,
    input  address,
    input  wren,
    output salida
  );
endinterface

// File: rtl/ram.sv
// Single-port 1024x32 synchronous data memory with a registered, write-through read port.
// The array has no reset so it maps onto a vendor block RAM.
module ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic  clock,
  input logic  rst_n,
  ram_if.slave bus
);
  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  // Declaration initialiser gives the all-zero power-up contents without reset logic.
  logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};
  logic [DATA_WIDTH-1:0] salida_q;

  // rst_n only gates the write; the array itself is never cleared.
  always_ff @(posedge clock) begin
    if (rst_n && bus.wren) begin
      mem[bus.address] <= bus.data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      salida_q <= '0;
    end else if (bus.wren) begin
      salida_q <= bus.data;
    end else begin
      salida_q <= mem[bus.address];
    end
  end

  assign bus.salida = salida_q;
endmodule

// File: tb/tb_ram.sv
// Scoreboard bench for ram: a driver pushes the expected read word per cycle, a monitor
// pops and compares one cycle later against a plain-array reference model.
module tb_ram;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic clock;
  logic rst_n;
  int   total;
  int   bad;

  logic [DW-1:0] model [1 << AW];
  logic [DW-1:0] exp_q [$];

  ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference rule: the word seen after an edge is the write data when writing, else the
  // stored word; nothing is written and the output is zero while reset is low.
  task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                      input logic r);
    @(negedge clock);
    rst_n       = r;
    bus.address = a;
    bus.data    = d;
    bus.wren    = w;
    if (!r) begin
      exp_q.push_back('0);
    end else if (w) begin
      exp_q.push_back(d);
      model[a] = d;
    end else begin
      exp_q.push_back(model[a]);
    end
  endtask

  // Monitor: the block is always ready, so every edge after a push presents a result.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("salida", bus.salida, e);
        @(negedge clock);
        #2;
        if (rst_n) check("salida_stable", bus.salida, e);
      end
    end
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    logic          r;
    int            waited;
    total = 0;
    bad   = 0;
    for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    rst_n       = 1'b0;
    bus.address = '0;
    bus.data    = '0;
    bus.wren    = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("reset_value", bus.salida, '0);

    // Basic write/readback and second location.
    step(10'd1, 32'd43, 1'b0, 1'b1);
    step(10'd1, 32'd43, 1'b1, 1'b1);
    step(10'd1, 32'd43, 1'b1, 1'b1);
    step(10'd1, 32'd43, 1'b0, 1'b1);
    step(10'd32, 32'd61, 1'b1, 1'b1);
    step(10'd32, 32'd61, 1'b1, 1'b1);
    step(10'd1, 32'd0, 1'b0, 1'b1);
    step(10'd32, 32'd0, 1'b0, 1'b1);
    // Write-enable gating.
    repeat (3) step(10'd1, 32'd99, 1'b0, 1'b1);
    // Read-during-write.
    step(10'd5, 32'd7, 1'b1, 1'b1);
    step(10'd5, 32'd8, 1'b1, 1'b1);
    step(10'd5, 32'd8, 1'b0, 1'b1);
    step(10'd32, 32'd0, 1'b0, 1'b1);

    // Reset falls mid-cycle during a pending write: output clears at once, write is lost.
    @(negedge clock);
    bus.address = 10'd32;
    bus.data    = 32'hDEAD_BEEF;
    bus.wren    = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("async_reset", bus.salida, '0);
    exp_q.push_back('0);
    step(10'd32, 32'h1, 1'b1, 1'b0);
    step(10'd32, 32'h0, 1'b0, 1'b1);

    // Boundary addresses and bit patterns.
    step(10'd1023, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step(10'd0, 32'h8000_0000, 1'b1, 1'b1);
    step(10'd1023, 32'h0, 1'b0, 1'b1);
    step(10'd0, 32'h0, 1'b0, 1'b1);
    step(10'd1022, 32'h0, 1'b0, 1'b1);
    step(10'd1, 32'h0, 1'b0, 1'b1);

    // Random traffic concentrated on a few hot addresses plus the boundaries.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: a = 10'd0;
        1: a = 10'd1023;
        2: a = AW'($urandom_range(0, 1023));
        default: a = AW'($urandom_range(0, 15));
      endcase
      d = $urandom();
      w = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 19) != 0);
      step(a, d, w, r);
    end
    step(10'd0, 32'h0, 1'b0, 1'b1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clock);
      waited++;
    end
    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
